// File: rtl/imem_wb_responder.sv
// imem_wb_responder: pipelined instruction-fetch responder with a fixed read latency and
// bounded outstanding requests. Define IMEM_RAND_STALL_EN to add LFSR-driven stalls.
module imem_wb_responder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned LATENCY   = 3,
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [31:0] INIT_WORD = 32'h0000_0013
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              inst_cyc_in,
   input  logic              inst_stb_in,
   input  logic [31:0]       inst_addr_in,
   output logic              inst_stall_out,
   output logic              inst_ack_out,
   output logic [31:0]       inst_data_out,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   // Contents survive reset; the initial value only applies at configuration time.
   logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

   logic              acc;
   logic [ADDR_W-1:0] acc_idx;
   logic              rd_vld;
   logic [ADDR_W-1:0] rd_idx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic [31:0]       data_q, data_d;
   logic              rand_stall;
   logic              unused_addr;

   assign acc_idx     = inst_addr_in[ADDR_W+1:2];
   assign unused_addr = ^{inst_addr_in[31:ADDR_W+2], inst_addr_in[1:0]};

`ifdef IMEM_RAND_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ 16'hB400;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rand_stall = (lfsr_q[1:0] == 2'b00);
`else
   assign rand_stall = 1'b0;
`endif

   assign inst_stall_out = (cnt_q == CNT_W'(MAX_OUTST)) | ~inst_cyc_in | rand_stall;
   assign acc            = inst_cyc_in & inst_stb_in & ~inst_stall_out;
   assign inst_ack_out   = ack_q & inst_cyc_in;
   assign inst_data_out  = data_q;

   // rd_vld/rd_idx describe the request leaving the next-to-last stage this cycle.
   generate
      if (LATENCY == 1) begin : g_direct
         assign rd_vld = acc;
         assign rd_idx = acc_idx;
      end else begin : g_pipe
         localparam int unsigned NS = LATENCY - 1;
         logic [NS-1:0]     vld_q, vld_d;
         logic [ADDR_W-1:0] idx_q [NS];
         logic [ADDR_W-1:0] idx_d [NS];

         always_comb begin
            vld_d    = '0;
            vld_d[0] = acc;
            idx_d[0] = acc_idx;
            for (int i = 1; i < int'(NS); i++) begin
               vld_d[i] = vld_q[i-1] & inst_cyc_in;
               idx_d[i] = idx_q[i-1];
            end
         end

         always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
               vld_q <= '0;
            end else begin
               vld_q <= vld_d;
            end
         end

         always_ff @(posedge sys_clk) begin
            idx_q <= idx_d;
         end

         assign rd_vld = vld_q[NS-1];
         assign rd_idx = idx_q[NS-1];
      end
   endgenerate

   always_comb begin
      ack_d  = inst_cyc_in & rd_vld;
      data_d = data_q;
      if (ack_d) begin
         data_d = mem[rd_idx];
      end
      cnt_d = cnt_q;
      if (!inst_cyc_in) begin
         cnt_d = '0;
      end else if (acc && !ack_q) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!acc && ack_q) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         cnt_q  <= '0;
         ack_q  <= 1'b0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ack_q  <= ack_d;
         data_q <= data_d;
      end
   end

   // A fetch reading a word on the same edge as a load sees the old contents.
   always_ff @(posedge sys_clk) begin
      if (load_we) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_imem_wb_responder.sv
// Self-checking bench for imem_wb_responder: queue-based reference model for the default
// build, plus a directed LATENCY=1 / MAX_OUTST=1 instance.
module tb_imem_wb_responder;
   localparam int          AW     = 10;
   localparam int          LAT    = 3;
   localparam int          MAXO   = 2;
   localparam logic [31:0] INIT_W = 32'h0000_0013;

   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   logic          cyc, stb, lwe, stall, ack;
   logic [31:0]   addr, ldata, rdata;
   logic [AW-1:0] laddr;

   logic          cyc1, stb1, lwe1, stall1, ack1;
   logic [31:0]   addr1, ldata1, rdata1;
   logic [AW-1:0] laddr1;

   imem_wb_responder #(.ADDR_W(AW), .LATENCY(LAT), .MAX_OUTST(MAXO), .INIT_WORD(INIT_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .inst_cyc_in(cyc), .inst_stb_in(stb), .inst_addr_in(addr),
      .inst_stall_out(stall), .inst_ack_out(ack), .inst_data_out(rdata),
      .load_we(lwe), .load_addr(laddr), .load_data(ldata)
   );

   imem_wb_responder #(.ADDR_W(AW), .LATENCY(1), .MAX_OUTST(1), .INIT_WORD(INIT_W)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .inst_cyc_in(cyc1), .inst_stb_in(stb1), .inst_addr_in(addr1),
      .inst_stall_out(stall1), .inst_ack_out(ack1), .inst_data_out(rdata1),
      .load_we(lwe1), .load_addr(laddr1), .load_data(ldata1)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: memory image plus a queue of accepted requests in order.
   // A request accepted at edge A acks in cycle A+LAT-1 and counts as outstanding
   // in cycles A..A+LAT-1; its word is captured just before edge A+LAT-1 applies loads.
   typedef struct {
      int          a;
      int          idx;
      logic [31:0] d;
   } req_t;

   logic [31:0] mem_m [1<<AW];
   req_t        pq[$];
   int          cyc_no = 0;
   logic        e_stall, e_ack;
   logic [31:0] e_data;
   logic [31:0] ack_log[$];
   int          ack_cyc[$];

   task automatic model_pre();
      while (pq.size() > 0 && pq[0].a + LAT - 1 < cyc_no) pq.delete(0);
      e_stall = (pq.size() == MAXO) || !cyc;
      e_ack   = 1'b0;
      e_data  = '0;
      if (cyc && pq.size() > 0 && pq[0].a + LAT - 1 == cyc_no) begin
         e_ack  = 1'b1;
         e_data = pq[0].d;
      end
   endtask

   task automatic model_edge();
      req_t r;
      logic acc;
      acc = cyc && stb && !e_stall;
      if (!cyc) pq.delete();
      foreach (pq[i]) begin
         if (pq[i].a + LAT - 1 == cyc_no + 1) begin
            r     = pq[i];
            r.d   = mem_m[r.idx];
            pq[i] = r;
         end
      end
      if (acc) begin
         r.a   = cyc_no + 1;
         r.idx = int'(addr[AW+1:2]);
         r.d   = (LAT == 1) ? mem_m[r.idx] : 32'h0;
         pq.push_back(r);
      end
      if (lwe) mem_m[laddr] = ldata;
      if (ack) begin
         ack_log.push_back(rdata);
         ack_cyc.push_back(cyc_no);
      end
      @(posedge sys_clk);
      #1;
      cyc_no++;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      cyc = 1'b1; stb = 1'b0; addr = '0; lwe = 1'b0; laddr = '0; ldata = '0;
      cyc1 = 1'b0; stb1 = 1'b0; addr1 = '0; lwe1 = 1'b0; laddr1 = '0; ldata1 = '0;
      #2;
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", rdata); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_cyc1 got=%b exp=0", stall); end
      cyc = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_cyc0 got=%b exp=1", stall); end
      @(posedge sys_clk); @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      cyc_no = 0;
   endtask

   task automatic test_single();
      int n0, cs;
      cyc = 1'b1; stb = 1'b0; lwe = 1'b1; laddr = AW'(5); ldata = 32'hDEADBEEF;
      n0 = ack_log.size();
      cs = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 1) begin lwe = 1'b0; stb = 1'b1; addr = 32'h14; cs = cyc_no; end
         if (k == 2) begin stb = 1'b0; addr = '0; end
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL single_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL single_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL single_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         model_edge();
      end
      checks++;
      if (ack_log.size() != n0 + 1) begin
         failures++; $display("FAIL single_count got=%0d exp=1", ack_log.size() - n0);
      end else if (ack_log[n0] !== 32'hDEADBEEF || ack_cyc[n0] != cs + 3) begin
         failures++; $display("FAIL single_word got=%h@%0d exp=deadbeef@%0d", ack_log[n0], ack_cyc[n0], cs + 3);
      end
   endtask

   task automatic test_stall_limit();
      int n0, s, n_acc;
      int obs_acc[$];
      int exp_acc[4] = '{0, 1, 4, 5};
      int exp_ack[4] = '{3, 4, 7, 8};
      cyc = 1'b1; stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lwe = 1'b1; laddr = AW'(i); ldata = 32'h1000_0000 + 32'(i) * 32'h111;
         #1; model_pre(); model_edge();
      end
      lwe = 1'b0;
      n0 = ack_log.size();
      s = cyc_no;
      n_acc = 0;
      for (int k = 0; k < 12; k++) begin
         stb = (n_acc < 4);
         addr = 32'(n_acc) * 4;
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL limit_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL limit_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL limit_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         if (stb && !stall) obs_acc.push_back(cyc_no - s);
         if (stb && !e_stall) n_acc++;
         model_edge();
      end
      stb = 1'b0;
      checks++;
      if (obs_acc.size() != 4 || ack_log.size() != n0 + 4) begin
         failures++; $display("FAIL limit_counts accepts=%0d acks=%0d exp=4/4", obs_acc.size(), ack_log.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (obs_acc[i] != exp_acc[i] || ack_cyc[n0+i] - s != exp_ack[i] ||
                ack_log[n0+i] !== 32'h1000_0000 + 32'(i) * 32'h111) begin
               failures++;
               $display("FAIL limit_seq i=%0d acc@%0d ack@%0d data=%h exp acc@%0d ack@%0d",
                        i, obs_acc[i], ack_cyc[n0+i] - s, ack_log[n0+i], exp_acc[i], exp_ack[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_abort();
      int n0, s;
      n0 = ack_log.size();
      s = cyc_no;
      for (int k = 0; k < 9; k++) begin
         cyc = (k != 2);
         stb = (k == 0 || k == 1 || k == 3);
         addr = (k == 0) ? 32'h0 : (k == 1) ? 32'h4 : 32'h8;
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL abort_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL abort_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL abort_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         model_edge();
      end
      cyc = 1'b1; stb = 1'b0;
      checks++;
      if (ack_log.size() != n0 + 1) begin
         failures++; $display("FAIL abort_count got=%0d exp=1", ack_log.size() - n0);
      end else if (ack_log[n0] !== 32'h1000_0222 || ack_cyc[n0] - s != 6) begin
         failures++; $display("FAIL abort_word got=%h@%0d exp=10000222@6", ack_log[n0], ack_cyc[n0] - s);
      end
   endtask

   task automatic test_collision();
      int n0;
      cyc = 1'b1; stb = 1'b0;
      lwe = 1'b1; laddr = AW'(7); ldata = 32'h1111_1111;
      #1; model_pre(); model_edge();
      lwe = 1'b0;
      n0 = ack_log.size();
      for (int k = 0; k < 9; k++) begin
         stb  = (k == 0 || k == 3);
         addr = 32'h1C;
         lwe  = (k == 2);
         laddr = AW'(7);
         ldata = 32'h2222_2222;
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL coll_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL coll_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL coll_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         model_edge();
      end
      stb = 1'b0; lwe = 1'b0;
      checks++;
      if (ack_log.size() != n0 + 2) begin
         failures++; $display("FAIL coll_count got=%0d exp=2", ack_log.size() - n0);
      end else if (ack_log[n0] !== 32'h1111_1111 || ack_log[n0+1] !== 32'h2222_2222) begin
         failures++; $display("FAIL coll_words got=%h,%h exp=11111111,22222222", ack_log[n0], ack_log[n0+1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1 [8];
      cyc = 1'b0; stb = 1'b0; lwe = 1'b0;
      cyc1 = 1'b1; stb1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w1[i] = 32'hB0B0_0000 + 32'(i) * 32'h0001_0011;
         lwe1 = 1'b1; laddr1 = AW'(i); ldata1 = w1[i];
         @(posedge sys_clk); #1;
      end
      lwe1 = 1'b0;
      @(posedge sys_clk); #1;
      for (int k = 0; k < 16; k++) begin
         stb1 = 1'b1;
         addr1 = 32'(k / 2) * 4;
         #1;
         checks++; if (stall1 !== (k % 2 == 1)) begin failures++; $display("FAIL b2b_stall k=%0d got=%b exp=%b", k, stall1, (k % 2 == 1)); end
         checks++; if (ack1 !== (k % 2 == 1)) begin failures++; $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, ack1, (k % 2 == 1)); end
         if (k % 2 == 1) begin
            checks++; if (rdata1 !== w1[k/2]) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rdata1, w1[k/2]); end
         end
         @(posedge sys_clk); #1;
      end
      stb1 = 1'b0; cyc1 = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int n0;
      cyc = 1'b1; stb = 1'b0;
      lwe = 1'b1; laddr = AW'(16); ldata = 32'hCAFE_0016;
      #1; model_pre(); model_edge();
      lwe = 1'b0;
      for (int k = 0; k < 4; k++) begin
         stb  = (k < 2);
         addr = (k == 0) ? 32'h40 : 32'h44;
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL mid_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL mid_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (k == 3) break;
         model_edge();
      end
      sys_rst = 1'b0;
      #1;
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", ack); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", rdata); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", stall); end
      pq.delete();
      @(posedge sys_clk); #1;
      cyc_no++;
      sys_rst = 1'b1;
      n0 = ack_log.size();
      for (int k = 0; k < 11; k++) begin
         stb  = (k == 6);
         addr = 32'h40;
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL post_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL post_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL post_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         model_edge();
      end
      stb = 1'b0;
      checks++;
      if (ack_log.size() != n0 + 1) begin
         failures++; $display("FAIL mid_count got=%0d exp=1", ack_log.size() - n0);
      end else if (ack_log[n0] !== 32'hCAFE_0016) begin
         failures++; $display("FAIL mid_preserved got=%h exp=cafe0016", ack_log[n0]);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         if (k < 490) begin
            cyc   = ($urandom_range(0, 19) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            addr  = $urandom & ~32'h0000_0FC0;
            lwe   = ($urandom_range(0, 3) == 0);
            laddr = AW'($urandom_range(0, 15));
            ldata = $urandom;
         end else begin
            cyc = 1'b1; stb = 1'b0; lwe = 1'b0;
         end
         #1;
         model_pre();
         checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc_no, stall, e_stall); end
         checks++; if (ack !== e_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc_no, ack, e_ack); end
         if (e_ack) begin
            checks++; if (rdata !== e_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc_no, rdata, e_data); end
         end
         model_edge();
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_m[i] = INIT_W;
      test_reset();
      test_single();
      test_stall_limit();
      test_abort();
      test_collision();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
